// File: rtl/tri_tlb_cache.sv
// ============================================================================
// Module   : tri_tlb_cache
// Purpose  : Small fully-associative translation cache in front of the
//            page-table walker. Hits are answered from local entries; a miss
//            issues one walker request, installs the returned PPN and then
//            acks the translator. One outstanding lookup at a time.
// Options  : TRI_TLB_PERF_EN adds saturating 32-bit hit_cnt / miss_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_tlb_cache #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 52,
  parameter int PPN_W   = 44
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [VPN_W-1:0] req_vpn,
  output logic             req_ack,
  output logic [PPN_W-1:0] req_ppn,
  output logic             ptw_req_valid,
  output logic [VPN_W-1:0] ptw_req_vpn,
  input  logic             ptw_req_ready,
  input  logic             ptw_resp_valid,
  input  logic [PPN_W-1:0] ptw_resp_ppn,
  input  logic             flush
`ifdef TRI_TLB_PERF_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
`endif
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RESP     = 2'd1;
  localparam logic [1:0] S_PTW_REQ  = 2'd2;
  localparam logic [1:0] S_PTW_WAIT = 2'd3;

  logic [1:0]         r_state;
  logic [ENTRIES-1:0] r_vld;
  logic [VPN_W-1:0]   r_tag [ENTRIES];
  logic [PPN_W-1:0]   r_ppn [ENTRIES];
  logic [VPN_W-1:0]   r_vpn;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_flush_pending;

  logic               w_hit;
  logic [PPN_W-1:0]   w_hit_ppn;
  logic               w_has_free;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_victim;
  logic               w_lookup;
  logic               w_install;

  // Acks and walker requests are pure functions of the registered state.
  assign req_ack       = (r_state == S_RESP);
  assign ptw_req_valid = (r_state == S_PTW_REQ);
  assign ptw_req_vpn   = r_vpn;

  // A lookup only starts in idle when no flush competes for the cycle.
  assign w_lookup  = (r_state == S_IDLE) && req_valid && !flush;
  // Install is dropped if a flush lands on, or happened during, this walk.
  assign w_install = (r_state == S_PTW_WAIT) && ptw_resp_valid && !flush && !r_flush_pending;

  // Parallel full-width tag compare; tags are unique so OR-merging is safe.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_vld[i] && (r_tag[i] == req_vpn)) begin
        w_hit     = 1'b1;
        w_hit_ppn = w_hit_ppn | r_ppn[i];
      end
    end
  end

  // Lowest-index invalid entry (descending scan leaves the lowest one).
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_vld[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_victim = w_has_free ? w_free_idx : r_ptr;

  // Control FSM, entry valid bits, replacement pointer and flush tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_vld           <= '0;
      r_ptr           <= '0;
      r_flush_pending <= 1'b0;
      r_vpn           <= '0;
      req_ppn         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_lookup) begin
            r_vpn <= req_vpn;
            if (w_hit) begin
              req_ppn <= w_hit_ppn;
              r_state <= S_RESP;
            end else begin
              r_state <= S_PTW_REQ;
            end
          end
        end
        S_RESP: r_state <= S_IDLE;
        S_PTW_REQ: begin
          if (ptw_req_ready) r_state <= S_PTW_WAIT;
        end
        S_PTW_WAIT: begin
          if (ptw_resp_valid) begin
            req_ppn <= ptw_resp_ppn;
            r_state <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (flush) begin
        r_vld <= '0;
      end else if (w_install) begin
        r_vld[w_victim] <= 1'b1;
        // Pointer only advances when a valid entry is evicted.
        if (!w_has_free) r_ptr <= r_ptr + IDX_W'(1);
      end

      if ((r_state == S_IDLE) || (r_state == S_RESP)) begin
        r_flush_pending <= 1'b0;
      end else if (flush) begin
        r_flush_pending <= 1'b1;
      end
    end
  end

  // Entry payload needs no reset: it is only visible behind a valid bit.
  always_ff @(posedge clk) begin
    if (w_install) begin
      r_tag[w_victim] <= r_vpn;
      r_ppn[w_victim] <= ptw_resp_ppn;
    end
  end

`ifdef TRI_TLB_PERF_EN
  // Saturating hit/miss counters; flush leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (w_lookup) begin
      if (w_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tri_tlb_cache.sv
// ============================================================================
// Module   : tb_tri_tlb_cache
// Purpose  : Scoreboard bench for tri_tlb_cache with a behavioural TLB model,
//            directed scenarios and randomized lookups.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tri_tlb_cache;

  localparam int ENTRIES = 8;
  localparam int VPN_W   = 52;
  localparam int PPN_W   = 44;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [VPN_W-1:0] req_vpn = '0;
  logic             req_ack;
  logic [PPN_W-1:0] req_ppn;
  logic             ptw_req_valid;
  logic [VPN_W-1:0] ptw_req_vpn;
  logic             ptw_req_ready = 1'b0;
  logic             ptw_resp_valid = 1'b0;
  logic [PPN_W-1:0] ptw_resp_ppn = '0;
  logic             flush = 1'b0;
`ifdef TRI_TLB_PERF_EN
  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;
`endif

  tri_tlb_cache #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_vpn(req_vpn), .req_ack(req_ack), .req_ppn(req_ppn),
    .ptw_req_valid(ptw_req_valid), .ptw_req_vpn(ptw_req_vpn), .ptw_req_ready(ptw_req_ready),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn), .flush(flush)
`ifdef TRI_TLB_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic [PPN_W-1:0] exp_q [$];

  // Reference model: a set of (vpn -> ppn) entries with slot positions.
  bit               m_vld [ENTRIES];
  logic [VPN_W-1:0] m_vpn [ENTRIES];
  logic [PPN_W-1:0] m_ppn [ENTRIES];
  int               m_ptr = 0;
  int               m_hits = 0;
  int               m_misses = 0;

  function automatic int m_find(input logic [VPN_W-1:0] v);
    for (int i = 0; i < ENTRIES; i++)
      if (m_vld[i] && m_vpn[i] == v) return i;
    return -1;
  endfunction

  function automatic void m_install(input logic [VPN_W-1:0] v, input logic [PPN_W-1:0] p);
    int slot;
    slot = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (!m_vld[i] && slot < 0) slot = i;
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % ENTRIES;
    end
    m_vld[slot] = 1'b1;
    m_vpn[slot] = v;
    m_ppn[slot] = p;
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
  endfunction

  function automatic void m_reset();
    m_flush();
    m_ptr    = 0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Protocol guard: the translator must hold its request through a miss.
  assert property (@(negedge clk) disable iff (!rst_n) ptw_req_valid |-> req_valid);

  // Walker handshake counter.
  initial forever begin
    @(negedge clk);
    if (rst_n && ptw_req_valid && ptw_req_ready) hs_cnt++;
  end

  // Monitor: every ack pops one expected PPN.
  initial forever begin
    @(negedge clk);
    if (rst_n && req_ack) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_ack", 64'(req_ppn), 64'd0);
      end else begin
        logic [PPN_W-1:0] e;
        e = exp_q.pop_front();
        check(req_ppn == e, "ack_ppn", 64'(req_ppn), 64'(e));
      end
    end
  end

  // One translator lookup, with the walker modelled in-line on a miss.
  task automatic lookup(input logic [VPN_W-1:0] vpn, input logic [PPN_W-1:0] ppn,
                        input int rdy_lat, input int rsp_lat, input bit flush_wait, input string tag);
    int idx, n, hs0;
    bit hit, seen, stable;
    idx = m_find(vpn);
    hit = (idx >= 0);
    hs0 = hs_cnt;
    if (hit) begin
      exp_q.push_back(m_ppn[idx]);
      m_hits++;
    end else begin
      exp_q.push_back(ppn);
      m_misses++;
    end
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_vpn   = vpn;
    if (!hit && rdy_lat == 0) ptw_req_ready = 1'b1;
    @(posedge clk);
    if (!hit) begin
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
        @(negedge clk); n++;
        seen = ptw_req_valid;
      end
      check(seen && ptw_req_vpn == vpn, {tag, "_ptw_req_vpn"}, 64'(ptw_req_vpn), 64'(vpn));
      if (rdy_lat > 0) begin
        stable = 1'b1;
        for (int k = 1; k < rdy_lat; k++) begin
          @(negedge clk);
          if (!(ptw_req_valid && ptw_req_vpn == vpn)) stable = 1'b0;
        end
        check(stable, {tag, "_ptw_hold_stable"}, 64'(stable), 64'd1);
        @(posedge clk); #1;
        ptw_req_ready = 1'b1;
      end
      @(posedge clk); #1;
      ptw_req_ready = 1'b0;
      for (int k = 0; k < rsp_lat; k++) begin
        if (flush_wait && k == 0) flush = 1'b1;
        if (k == rsp_lat - 1) begin
          ptw_resp_valid = 1'b1;
          ptw_resp_ppn   = ppn;
        end
        @(posedge clk); #1;
        flush          = 1'b0;
        ptw_resp_valid = 1'b0;
      end
      if (flush_wait) m_flush();
      else            m_install(vpn, ppn);
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk); n++;
      seen = req_ack;
    end
    check(seen && n == 1, {tag, "_ack_latency"}, 64'(n), 64'd1);
    req_valid = 1'b0;
    check(hs_cnt == hs0 + (hit ? 0 : 1), {tag, "_walker_requests"}, 64'(hs_cnt - hs0), 64'(hit ? 0 : 1));
  endtask

  task automatic idle_flush();
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    m_flush();
  endtask

  initial begin
    int n_ack;
    m_reset();
    // Reset state
    #2;
    check(!req_ack && req_ppn == '0 && !ptw_req_valid && ptw_req_vpn == '0, "reset_outputs",
          {11'd0, req_ack, ptw_req_valid, 51'(req_ppn)}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Cold miss and repeat hit
    lookup(52'h12345, 44'hABC, 0, 3, 1'b0, "cold_miss");
    lookup(52'h12345, 44'h0,   0, 1, 1'b0, "hit");
`ifdef TRI_TLB_PERF_EN
    check(hit_cnt == 32'd1, "hit_cnt_after_hit", 64'(hit_cnt), 64'd1);
`endif

    // Fill, round-robin wrap, then hit on 0x2 and miss on 0x0
    idle_flush();
    for (int v = 0; v < 10; v++)
      lookup(52'(v), 44'(16'h100 + v), v % 3, 1 + (v % 3), 1'b0, "fill");
    lookup(52'h2, 44'h0,   0, 1, 1'b0, "wrap_hit2");
    lookup(52'h0, 44'h200, 1, 2, 1'b0, "wrap_miss0");

    // Walker backpressure
    lookup(52'h2000, 44'h321, 5, 2, 1'b0, "backpressure");

    // Flush during walk, then repeats miss again
    lookup(52'h77, 44'h55, 0, 3, 1'b1, "flush_walk");
    lookup(52'h77, 44'h56, 0, 2, 1'b0, "flush_walk_repeat");
    lookup(52'h2,  44'h57, 0, 1, 1'b0, "flush_walk_old");

    // Flush competing with a request in idle starts no lookup
    @(posedge clk); #1; req_valid = 1'b1; req_vpn = 52'h77; flush = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
    m_flush();
    @(negedge clk);
    check(!req_ack && !ptw_req_valid, "flush_blocks_lookup", {62'd0, req_ack, ptw_req_valid}, 64'd0);

    // Reset mid-walk: late response must be ignored
    @(posedge clk); #1; req_valid = 1'b1; req_vpn = 52'h999; ptw_req_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1; ptw_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0;
    m_reset();
    #1;
    check(!req_ack && req_ppn == '0 && !ptw_req_valid && ptw_req_vpn == '0, "reset_midwalk_outputs",
          {11'd0, req_ack, ptw_req_valid, 51'(req_ppn)}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; ptw_resp_valid = 1'b1; ptw_resp_ppn = 44'hDEAD;
    @(posedge clk); #1; ptw_resp_valid = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (req_ack || ptw_req_valid) n_ack++;
    end
    check(n_ack == 0, "late_resp_ignored", 64'(n_ack), 64'd0);
    lookup(52'h12345, 44'hBEE, 0, 1, 1'b0, "after_reset");

    // Randomized lookups from a small VPN pool to force hits and evictions
    for (int i = 0; i < 60; i++) begin
      logic [VPN_W-1:0] v;
      int rsp;
      if ($urandom_range(0, 14) == 0) idle_flush();
      v   = 52'h4000 + 52'($urandom_range(0, 11));
      rsp = $urandom_range(1, 4);
      lookup(v, 44'($urandom), $urandom_range(0, 3), rsp, ($urandom_range(0, 9) == 0), "rand");
    end

    repeat (3) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef TRI_TLB_PERF_EN
    check(hit_cnt == 32'(m_hits), "hit_cnt_final", 64'(hit_cnt), 64'(m_hits));
    check(miss_cnt == 32'(m_misses), "miss_cnt_final", 64'(miss_cnt), 64'(m_misses));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
